// File: rtl/alu_flags_pkg.sv
// Shared definitions for the ALU status-flag blocks (N, Z, C, V).
// Holds the default datapath width, status-register bit positions and operation classes.
package alu_flags_pkg;

  localparam int ALU_WIDTH = 4;

  // Bit positions of each flag inside the status register.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    OP_CLASS_LOGIC = 1'b0,
    OP_CLASS_ARITH = 1'b1
  } op_class_e;

  // Upstream decoders turn an operation class into the is_arithmetic qualifier.
  function automatic logic op_is_arithmetic(input op_class_e op_class);
    return (op_class == OP_CLASS_ARITH);
  endfunction

endpackage

// File: rtl/negative_flag.sv
// Combinational N-flag term: the result sign bit, qualified by the arithmetic-operation class.
module negative_flag
  import alu_flags_pkg::*;
(
  input  logic msb,
  input  logic is_arithmetic,
  output logic is_negative
);

  // Logic operations never report negative; unknowns on either input may propagate.
  assign is_negative = msb & is_arithmetic;

endmodule

// File: rtl/alu_negative_flag.sv
// N (negative) status flag: same-cycle combinational flag plus its status-register copy.
module alu_negative_flag
  import alu_flags_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] result,
  input  logic             is_arithmetic,
  input  logic             flag_we,
  output logic             is_negative,
  output logic             negative_q
);

  // Only the sign bit matters; the lower bits are gathered here purely to mark them as don't-care.
  logic unused_low_bits;
  assign unused_low_bits = ^result[WIDTH-2:0];

  negative_flag u_negative_flag (
    .msb           (result[WIDTH-1]),
    .is_arithmetic (is_arithmetic),
    .is_negative   (is_negative)
  );

  // Reset wins over the write enable; otherwise the flag holds until written.
  always_ff @(posedge clk) begin
    if (rst) begin
      negative_q <= 1'b0;
    end else if (flag_we) begin
      negative_q <= is_negative;
    end
  end

endmodule

// File: tb/tb_alu_negative_flag.sv
// Directed bench for alu_negative_flag: expected values are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled, for WIDTH = 4 and WIDTH = 8.
module tb_alu_negative_flag;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] result;
  logic       is_arithmetic;
  logic       flag_we;
  logic       is_negative;
  logic       negative_q;

  logic [7:0] result8;
  logic       is_arithmetic8;
  logic       is_negative8;
  logic       negative_q8;

  int tests_run    = 0;
  int tests_failed = 0;

  logic  exp_q[$];
  string tag_q[$];
  logic  model_q;

  always #5 clk = ~clk;

  alu_negative_flag #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .result        (result),
    .is_arithmetic (is_arithmetic),
    .flag_we       (flag_we),
    .is_negative   (is_negative),
    .negative_q    (negative_q)
  );

  alu_negative_flag #(.WIDTH(8)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .result        (result8),
    .is_arithmetic (is_arithmetic8),
    .flag_we       (1'b0),
    .is_negative   (is_negative8),
    .negative_q    (negative_q8)
  );

  task automatic pushExpected(input logic e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input logic observed);
    logic  e;
    string t;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty observed=%b expected=<none>", observed);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (observed === e) else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%b expected=%b", t, observed, e);
      end
    end
  endtask

  // Drive the 4-bit DUT away from the clock edge, let it settle, queue the expected comb flag.
  task automatic applyStimulus(input logic [3:0] r, input logic a, input string tag);
    @(negedge clk);
    result        = r;
    is_arithmetic = a;
    flag_we       = 1'b0;
    rst           = 1'b0;
    #1;
    pushExpected(r[3] & a, tag);
  endtask

  // One register cycle: inputs set at negedge, negative_q sampled #1 after the rising edge.
  task automatic clockCycle(input logic r_rst, input logic we, input logic [3:0] r,
                            input logic a, input string tag);
    @(negedge clk);
    rst           = r_rst;
    flag_we       = we;
    result        = r;
    is_arithmetic = a;
    @(posedge clk);
    if (r_rst)   model_q = 1'b0;
    else if (we) model_q = r[3] & a;
    #1;
    pushExpected(model_q, tag);
    checkOutput(negative_q);
  endtask

  initial begin
    rst            = 1'b0;
    flag_we        = 1'b0;
    result         = 4'd0;
    is_arithmetic  = 1'b0;
    result8        = 8'd0;
    is_arithmetic8 = 1'b0;
    model_q        = 1'b0;

    clockCycle(1'b1, 1'b0, 4'd0, 1'b0, "reset_clears_q");
    pushExpected(1'b0, "reset_clears_q_w8");
    checkOutput(negative_q8);

    applyStimulus(4'd5,  1'b1, "arith_pos5");   checkOutput(is_negative);
    applyStimulus(4'd0,  1'b1, "arith_zero");   checkOutput(is_negative);
    applyStimulus(4'hB,  1'b1, "arith_neg5");   checkOutput(is_negative);
    applyStimulus(4'd0,  1'b1, "arith_zero2");  checkOutput(is_negative);

    applyStimulus(4'd5,  1'b0, "logic_pos5");   checkOutput(is_negative);
    applyStimulus(4'd0,  1'b0, "logic_zero");   checkOutput(is_negative);
    applyStimulus(4'hB,  1'b0, "logic_neg5");   checkOutput(is_negative);
    applyStimulus(4'd0,  1'b0, "logic_zero2");  checkOutput(is_negative);

    applyStimulus(4'h8,  1'b1, "arith_min");    checkOutput(is_negative);
    applyStimulus(4'hF,  1'b1, "arith_all1");   checkOutput(is_negative);
    applyStimulus(4'h7,  1'b1, "low_bits_111"); checkOutput(is_negative);
    applyStimulus(4'h2,  1'b1, "low_bits_010"); checkOutput(is_negative);

    clockCycle(1'b0, 1'b1, 4'hB, 1'b1, "load_neg");
    clockCycle(1'b0, 1'b0, 4'd5, 1'b1, "hold_1");
    clockCycle(1'b0, 1'b0, 4'd5, 1'b1, "hold_2");
    clockCycle(1'b0, 1'b1, 4'd5, 1'b1, "load_pos");

    clockCycle(1'b0, 1'b1, 4'hB, 1'b1, "reload_neg");
    clockCycle(1'b1, 1'b1, 4'hB, 1'b1, "reset_priority");
    pushExpected(1'b1, "comb_ignores_reset");
    checkOutput(is_negative);
    clockCycle(1'b0, 1'b1, 4'hB, 1'b1, "resume_after_reset");

    for (int a = 0; a < 2; a++) begin
      for (int v = 0; v < 16; v++) begin
        applyStimulus(4'(v), 1'(a), $sformatf("sweep_a%0d_r%0d", a, v));
        checkOutput(is_negative);
      end
    end

    @(negedge clk);
    result8 = 8'h80; is_arithmetic8 = 1'b1; #1;
    pushExpected(1'b1, "w8_min"); checkOutput(is_negative8);
    result8 = 8'h7F; #1;
    pushExpected(1'b0, "w8_max_pos"); checkOutput(is_negative8);
    result8 = 8'hFF; is_arithmetic8 = 1'b0; #1;
    pushExpected(1'b0, "w8_logic_neg"); checkOutput(is_negative8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
